// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight destination registers from EXE to WB,
// drives operand bypass selects and the load-use / long-latency ID stall.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   id_valid         ID holds a real instruction
//   id_rs, id_rt     source indices; id_use_rs/id_use_rt qualify them
//   id_wen, id_dest  ID destination write enable and index
//   id_avail         first entry at which the ID result can be forwarded
//   pipe_hold        freeze the whole pipe
//   flush            kill every in-flight entry
//   id_stall         ID must hold, a bubble enters EXE
//   fwd_a, fwd_b     bypass select: 0 = regfile, k+1 = entry k
//   stall_count      saturating count of effective stall cycles
module hazard_scoreboard #(
   parameter int DEPTH = 3,
   parameter int REG_W = 5,
   parameter int AW    = $clog2(DEPTH),
   parameter int FW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic             id_wen,
   input  logic [REG_W-1:0] id_dest,
   input  logic [AW-1:0]    id_avail,
   input  logic             pipe_hold,
   input  logic             flush,
   output logic             id_stall,
   output logic [FW-1:0]    fwd_a,
   output logic [FW-1:0]    fwd_b,
   output logic [31:0]      stall_count
);

   typedef struct packed {
      logic             valid;
      logic             wen;
      logic [REG_W-1:0] dest;
      logic [AW-1:0]    avail;
   } entry_t;

   entry_t ent [DEPTH];

   logic [AW-1:0] avail_in;
   logic          hit_a, haz_a;
   logic          hit_b, haz_b;
   logic [FW-1:0] sel_a, sel_b;

   // Clamping to the WB index keeps every stored avail reachable,
   // so the oldest entry can always forward.
   always_comb begin
      avail_in = id_avail;
      if (int'(id_avail) >= DEPTH)
         avail_in = AW'(DEPTH - 1);
   end

   // Scan oldest to youngest so the youngest match is the last write.
   always_comb begin
      hit_a = 1'b0;
      haz_a = 1'b0;
      sel_a = '0;
      hit_b = 1'b0;
      haz_b = 1'b0;
      sel_b = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (ent[k].valid && ent[k].wen && ent[k].dest != '0) begin
            if (ent[k].dest == id_rs) begin
               hit_a = 1'b1;
               sel_a = FW'(k + 1);
               haz_a = (k < int'(ent[k].avail));
            end
            if (ent[k].dest == id_rt) begin
               hit_b = 1'b1;
               sel_b = FW'(k + 1);
               haz_b = (k < int'(ent[k].avail));
            end
         end
      end
   end

   always_comb begin
      id_stall = ~rst & id_valid &
                 ((id_use_rs & haz_a) | (id_use_rt & haz_b));
      fwd_a = '0;
      fwd_b = '0;
      if (!rst && id_valid && id_use_rs && hit_a)
         fwd_a = sel_a;
      if (!rst && id_valid && id_use_rt && hit_b)
         fwd_b = sel_b;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++)
            ent[k] <= '0;
         stall_count <= '0;
      end else if (flush) begin
         for (int k = 0; k < DEPTH; k++)
            ent[k].valid <= 1'b0;
      end else if (!pipe_hold) begin
         for (int k = DEPTH - 1; k > 0; k--)
            ent[k] <= ent[k-1];
         ent[0].valid <= id_valid & ~id_stall;
         ent[0].wen   <= id_wen;
         ent[0].dest  <= id_dest;
         ent[0].avail <= avail_in;
         if (id_stall && stall_count != '1)
            stall_count <= stall_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scenarios plus random traffic checked
// against a queue-based model of in-flight instructions.
module tb_hazard_scoreboard;

   localparam int DEPTH = 3;
   localparam int REG_W = 5;
   localparam int AW    = $clog2(DEPTH);
   localparam int FW    = $clog2(DEPTH + 1);

   logic             clk;
   logic             rst;
   logic             id_valid;
   logic [REG_W-1:0] id_rs;
   logic [REG_W-1:0] id_rt;
   logic             id_use_rs;
   logic             id_use_rt;
   logic             id_wen;
   logic [REG_W-1:0] id_dest;
   logic [AW-1:0]    id_avail;
   logic             pipe_hold;
   logic             flush;
   logic             id_stall;
   logic [FW-1:0]    fwd_a;
   logic [FW-1:0]    fwd_b;
   logic [31:0]      stall_count;

   hazard_scoreboard #(
      .DEPTH(DEPTH),
      .REG_W(REG_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .id_valid(id_valid),
      .id_rs(id_rs),
      .id_rt(id_rt),
      .id_use_rs(id_use_rs),
      .id_use_rt(id_use_rt),
      .id_wen(id_wen),
      .id_dest(id_dest),
      .id_avail(id_avail),
      .pipe_hold(pipe_hold),
      .flush(flush),
      .id_stall(id_stall),
      .fwd_a(fwd_a),
      .fwd_b(fwd_b),
      .stall_count(stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int wen;
      int dest;
      int avail;
      int stage;
   } rec_t;

   rec_t q[$];
   logic [31:0] mcnt;
   int vectors;
   int miscompares;
   int m_stall;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void lookup(input int s, output int found,
                                  output int sel, output int haz);
      int best;
      best  = 1000;
      found = 0;
      sel   = 0;
      haz   = 0;
      foreach (q[i]) begin
         if (q[i].wen != 0 && q[i].dest == s && s != 0 &&
             q[i].stage < best) begin
            best  = q[i].stage;
            found = 1;
            sel   = best + 1;
            haz   = (best < q[i].avail) ? 1 : 0;
         end
      end
   endfunction

   task automatic sample();
      int fa, sa, ha, fb, sb, hb, ea, eb;
      @(negedge clk);
      lookup(int'(id_rs), fa, sa, ha);
      lookup(int'(id_rt), fb, sb, hb);
      m_stall = (!rst && id_valid &&
                 ((id_use_rs && ha != 0) || (id_use_rt && hb != 0))) ? 1 : 0;
      ea = (!rst && id_valid && id_use_rs && fa != 0) ? sa : 0;
      eb = (!rst && id_valid && id_use_rt && fb != 0) ? sb : 0;
      chk("model_fwd_a", 32'(fwd_a), 32'(ea));
      chk("model_fwd_b", 32'(fwd_b), 32'(eb));
      chk("model_stall", 32'(id_stall), 32'(m_stall));
      chk("model_count", stall_count, mcnt);
   endtask

   task automatic advance();
      rec_t nq[$];
      rec_t r;
      int av;
      if (rst) begin
         q.delete();
         mcnt = '0;
      end else if (flush) begin
         q.delete();
      end else if (!pipe_hold) begin
         if (m_stall != 0 && mcnt != 32'hFFFF_FFFF)
            mcnt = mcnt + 32'd1;
         foreach (q[i]) begin
            r = q[i];
            r.stage++;
            if (r.stage < DEPTH)
               nq.push_back(r);
         end
         if (id_valid && m_stall == 0) begin
            av = int'(id_avail);
            if (av > DEPTH - 1)
               av = DEPTH - 1;
            r = '{wen: int'(id_wen), dest: int'(id_dest),
                  avail: av, stage: 0};
            nq.push_back(r);
         end
         q = nq;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic cycle();
      sample();
      advance();
   endtask

   task automatic set_id(input logic v, input int rs, input int rt,
                         input logic urs, input logic urt,
                         input logic wen, input int dest, input int av);
      id_valid  = v;
      id_rs     = REG_W'(rs);
      id_rt     = REG_W'(rt);
      id_use_rs = urs;
      id_use_rt = urt;
      id_wen    = wen;
      id_dest   = REG_W'(dest);
      id_avail  = AW'(av);
   endtask

   task automatic nops(input int n);
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < n; i++)
         cycle();
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      mcnt        = '0;
      m_stall     = 0;
      rst         = 1'b1;
      pipe_hold   = 1'b0;
      flush       = 1'b0;
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      sample();
      chk("reset_stall", 32'(id_stall), 32'd0);
      chk("reset_count", stall_count, 32'd0);
      advance();
      rst = 1'b0;

      // ALU result forwarded from each stage in turn
      set_id(1, 1, 2, 1, 1, 1, 3, 0);
      cycle();
      set_id(1, 3, 4, 1, 1, 1, 5, 0);
      sample();
      chk("alu_fwd_a_e0", 32'(fwd_a), 32'd1);
      chk("alu_fwd_b_e0", 32'(fwd_b), 32'd0);
      chk("alu_stall", 32'(id_stall), 32'd0);
      advance();
      set_id(1, 3, 0, 1, 0, 0, 0, 0);
      sample();
      chk("alu_fwd_a_e1", 32'(fwd_a), 32'd2);
      advance();
      sample();
      chk("alu_fwd_a_e2", 32'(fwd_a), 32'd3);
      advance();
      sample();
      chk("alu_fwd_a_gone", 32'(fwd_a), 32'd0);
      advance();
      nops(3);

      // load-use: one stall cycle, then forward from entry 1
      set_id(1, 0, 0, 0, 0, 1, 4, 1);
      cycle();
      set_id(1, 0, 4, 0, 1, 0, 0, 0);
      sample();
      chk("lu_stall", 32'(id_stall), 32'd1);
      chk("lu_fwd_b_sel", 32'(fwd_b), 32'd1);
      advance();
      sample();
      chk("lu_stall_done", 32'(id_stall), 32'd0);
      chk("lu_fwd_b", 32'(fwd_b), 32'd2);
      chk("lu_count", stall_count, 32'd1);
      advance();
      nops(3);

      // r0 and non-writing producers never forward
      set_id(1, 0, 0, 0, 0, 1, 0, 0);
      cycle();
      set_id(1, 0, 0, 1, 1, 0, 0, 0);
      sample();
      chk("r0_fwd_a", 32'(fwd_a), 32'd0);
      chk("r0_stall", 32'(id_stall), 32'd0);
      advance();
      set_id(1, 0, 0, 0, 0, 0, 7, 0);
      cycle();
      set_id(1, 7, 7, 1, 1, 0, 0, 0);
      sample();
      chk("nowen_fwd_a", 32'(fwd_a), 32'd0);
      advance();
      nops(3);

      // youngest writer wins
      set_id(1, 0, 0, 0, 0, 1, 5, 0);
      cycle();
      nops(1);
      set_id(1, 0, 0, 0, 0, 1, 5, 0);
      cycle();
      set_id(1, 5, 5, 1, 1, 0, 0, 0);
      sample();
      chk("young_fwd_a", 32'(fwd_a), 32'd1);
      chk("young_fwd_b", 32'(fwd_b), 32'd1);
      advance();
      nops(3);

      // hold freezes a load-use stall; flush under hold clears it
      set_id(1, 0, 0, 0, 0, 1, 6, 1);
      cycle();
      set_id(1, 6, 0, 1, 0, 0, 0, 0);
      pipe_hold = 1'b1;
      for (int i = 0; i < 4; i++) begin
         sample();
         chk("hold_stall", 32'(id_stall), 32'd1);
         chk("hold_count", stall_count, 32'd1);
         advance();
      end
      flush = 1'b1;
      cycle();
      flush     = 1'b0;
      pipe_hold = 1'b0;
      sample();
      chk("flush_stall", 32'(id_stall), 32'd0);
      chk("flush_fwd_a", 32'(fwd_a), 32'd0);
      chk("flush_count", stall_count, 32'd1);
      advance();
      nops(3);

      // reset mid-stream, then normal tracking resumes
      set_id(1, 0, 0, 0, 0, 1, 8, 0);
      cycle();
      set_id(1, 0, 0, 0, 0, 1, 9, 1);
      cycle();
      set_id(1, 0, 0, 0, 0, 1, 10, 1);
      cycle();
      set_id(1, 9, 10, 1, 1, 0, 0, 0);
      rst = 1'b1;
      sample();
      chk("rst_fwd_a", 32'(fwd_a), 32'd0);
      chk("rst_stall", 32'(id_stall), 32'd0);
      advance();
      rst = 1'b0;
      sample();
      chk("post_fwd_a", 32'(fwd_a), 32'd0);
      chk("post_fwd_b", 32'(fwd_b), 32'd0);
      chk("post_stall", 32'(id_stall), 32'd0);
      chk("post_count", stall_count, 32'd0);
      advance();
      set_id(1, 0, 0, 0, 0, 1, 11, 0);
      cycle();
      set_id(1, 11, 0, 1, 0, 0, 0, 0);
      sample();
      chk("post_track", 32'(fwd_a), 32'd1);
      advance();

      // random traffic against the model
      for (int i = 0; i < 600; i++) begin
         set_id(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0,
                int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                1'($urandom), 1'($urandom), 1'($urandom),
                int'($urandom_range(0, 7)),
                int'($urandom_range(0, (1 << AW) - 1)));
         pipe_hold = ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0;
         flush     = ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0;
         rst       = ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0;
         cycle();
      end
      rst       = 1'b0;
      pipe_hold = 1'b0;
      flush     = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the fixed decode-stage forwarding controls (`fwda`/`fwdb` from single EXE/MEM register compares).
- Tracks destination-register state of every in-flight instruction between decode and writeback across `DEPTH` stages.
- Generates per-operand forwarding selects and a load-use/long-latency interlock stall for the ID stage.
- Sits beside the decoder; the datapath bypass muxes consume `fwd_a`/`fwd_b`.

Parameters:
- `DEPTH`, 3, number of tracked stages after ID (entry 0 = EXE, entry `DEPTH`-1 = WB); legal 2..8.
- `REG_W`, 5, register-index width.
- `AW`, `$clog2(DEPTH)`, width of the availability-stage field.
- `FW`, `$clog2(DEPTH+1)`, width of the forwarding selects.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `id_valid`  in  1  ID holds a real instruction this cycle.
- `id_rs`  in  `REG_W`  source A index.
- `id_rt`  in  `REG_W`  source B index.
- `id_use_rs`  in  1  instruction reads `rs`.
- `id_use_rt`  in  1  instruction reads `rt`.
- `id_wen`  in  1  instruction writes the regfile.
- `id_dest`  in  `REG_W`  destination index (rd/rt/31 already selected).
- `id_avail`  in  `AW`  first entry index at which the result is forwardable (0 = ALU, 1 = load, ...).
- `pipe_hold`  in  1  whole pipe frozen (cache/mem stall).
- `flush`  in  1  kill all in-flight entries (exception/eret).
- `id_stall`  out  1  ID must hold; a bubble is inserted into EXE.
- `fwd_a`  out  `FW`  source-A select: 0 = regfile, k+1 = entry k.
- `fwd_b`  out  `FW`  source-B select, same encoding.
- `stall_count`  out  32  number of cycles `id_stall` = 1 and `pipe_hold` = 0; saturates at 0xFFFFFFFF.

Behaviour:
- Per-entry state: `valid`, `wen`, `dest`[`REG_W`], `avail`[`AW`].
- Reset clears all entries and `stall_count`. While `rst` is high or at reset release: `id_stall` = 0, `fwd_a` = `fwd_b` = 0.
- Match for source s: entry valid & `wen` & `dest` == s & `dest` != 0. Register 0 never matches.
- Youngest match wins (lowest k). `fwd_x` = k+1 if k >= entry `avail`; otherwise that operand is hazarded.
- `fwd_x` = 0 when there is no match, or when `id_use_x` = 0, or when `id_valid` = 0.
- `id_stall` = `id_valid` & ((`use_rs` & hazard_rs) | (`use_rt` & hazard_rt)).
- `fwd_x` is don't-care while `id_stall` = 1, but must be the selected k+1 value.
- All outputs except `stall_count` are combinational from current state and ID inputs (zero latency).
- `id_avail` >= `DEPTH` is clamped to `DEPTH`-1.
- Update priority per edge: `rst` > `flush` > `pipe_hold` > advance.
  - `flush`: all entries invalid, including when `pipe_hold` = 1 the same cycle. ID is not captured.
  - `pipe_hold`: all entries unchanged. `stall_count` unchanged.
  - Advance: entry k -> k+1 for k < `DEPTH`-1. Entry `DEPTH`-1 retires (dropped).
  - Entry 0 <= {`id_valid` & !`id_stall`, `id_wen`, `id_dest`, `id_avail`}; a stall inserts an invalid bubble.
- WB entry (`DEPTH`-1) is forwarded because the regfile has no internal write-through. Its `avail` is always satisfied.
- A load-use gap of n stages stalls exactly `avail` - k cycles, then forwards from entry `avail`.
- `stall_count` increments on edges where `id_stall` = 1 & !`pipe_hold` & !`flush` & !`rst`.
- No ready/valid handshake toward ID beyond `id_stall`. ID must keep its inputs stable while stalled.

Test Plan:
- `DEPTH`=3: issue addu r3 (`avail`=0), next cycle addu r5,r3,r4 -> `id_stall`=0, `fwd_a`=1, `fwd_b`=0. One cycle later use r3 -> `fwd_a`=2; two later -> `fwd_a`=3; three later -> `fwd_a`=0.
- lw r4 (`avail`=1) then immediate use of r4 on rt -> `id_stall`=1 for exactly 1 cycle, entry 0 becomes a bubble, then `fwd_b`=2, `stall_count`=1.
- Writer dest r0 with `wen`=1, then consumer of r0 -> `fwd_a`=0, `id_stall`=0. Writer r7 with `wen`=0 -> no forward.
- Writes r5 in entry 2 and entry 0, consumer reads r5 on both rs and rt -> `fwd_a`=`fwd_b`=1 (youngest wins).
- lw r6 in entry 0 with `pipe_hold`=1 for 4 cycles, consumer of r6 -> `id_stall` held 4 cycles, `stall_count` unchanged. Then `flush`=1 with `pipe_hold`=1 -> next cycle all entries invalid, `id_stall`=0, `fwd_a`=0.
- Fill all entries, assert `rst` for 1 cycle mid-stream -> next cycle `fwd_a`=`fwd_b`=0, `id_stall`=0, `stall_count`=0. The first post-reset issue is tracked normally.
